wb_trace_unit: RTL and testbench
================================

WB_TRACE_UNIT -- requirements
Module: wb_trace_unit

Interface
REQ-001 Parameters, one per line:
- DEPTH, 8, event FIFO entries (power of two, >=2).
- HALT_PC, 32'h58, program-completion PC.

REQ-002 Ports, one per line:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset.
- pc, input, 32, fetch-stage PC of the pipeline top.
- wb_regwrite, input, 1, writeback-stage register-write enable.
- wb_writereg, input, 5, writeback destination register.
- wb_result, input, 32, writeback data.
- ev_valid, output, 1, head event available.
- ev_ready, input, 1, consumer accepts head event.
- ev_reg, output, 5, head event register.
- ev_data, output, 32, head event data.
- halted, output, 1, run complete and FIFO drained.
- overflow, output, 1, sticky event-dropped flag.
- fifo_count, output, $clog2(DEPTH)+1, current occupancy.
- cycle_count, output, 32, cycles spent in RUN.
- write_count, output, 32, qualifying writebacks seen in RUN.

Function
REQ-003 Qualifying event: wb_regwrite=1 and wb_writereg!=0, sampled on a rising edge while state=RUN.
REQ-004 Qualifying event SHALL be pushed as {wb_writereg, wb_result}; it is visible at the head no earlier than the next cycle (1-cycle latency when FIFO was empty).
REQ-005 Pop SHALL occur on a rising edge with ev_valid=1 and ev_ready=1; ev_reg/ev_data SHALL hold stable while ev_valid=1 and ev_ready=0.
REQ-006 ev_valid SHALL equal (fifo_count!=0).
REQ-007 Full and push without pop: event dropped, overflow set to 1 until reset, write_count still incremented.
REQ-008 Full with simultaneous push and pop: both accepted, fifo_count unchanged, overflow unaffected.
REQ-009 Empty with push: no bypass; ev_valid rises the following cycle.
REQ-010 FIFO pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH.
REQ-011 States: RUN, DRAIN, DONE.
REQ-012 RUN -> DRAIN on the edge where pc==HALT_PC; a qualifying event in that same cycle IS captured.
REQ-013 DRAIN -> DONE on the edge where fifo_count==0 (including a pop to zero on the prior edge); DRAIN ignores writeback inputs.
REQ-014 DONE is terminal until reset; halted=1 only in DONE.
REQ-015 cycle_count increments every edge in RUN (including the halt-detect edge), frozen otherwise; write_count increments per qualifying event in RUN; both saturate at 32'hFFFFFFFF.
REQ-016 Pops remain legal in DRAIN and DONE.

Reset
REQ-017 reset=0 SHALL immediately force: state RUN, FIFO empty, ev_valid=0, ev_reg=0, ev_data=0, halted=0, overflow=0, fifo_count=0, cycle_count=0, write_count=0.
REQ-018 Reset asserted mid-run or mid-drain discards all FIFO contents; no event is emitted after reset release until a new push.
REQ-019 First edge after reset release SHALL count as a RUN cycle.

Structure
REQ-020 Shared package holds the state enum (RUN/DRAIN/DONE), event record type {reg[4:0], data[31:0]}, and default DEPTH/HALT_PC constants.
REQ-021 FIFO storage and pointers live in one sub-module, wb_event_fifo (push, pop, full, empty, count); FSM and counters stay in wb_trace_unit.

Verification
REQ-022 Writes r8=5, r9=7, r0=3 on consecutive cycles, ev_ready=1 -> exactly two events (8,5),(9,7) in order, write_count=2.
REQ-023 ev_ready=0, 9 qualifying writes with DEPTH=8 -> fifo_count=8, overflow=1, write_count=9, first 8 events intact and in order.
REQ-024 FIFO full, push and pop in same cycle -> fifo_count stays 8, overflow stays 0, popped event is the oldest.
REQ-025 pc=32'h58 together with write r2=32'hAB, ev_ready held 0 for 3 cycles -> state DRAIN, event captured, cycle_count frozen; halted=1 one edge after last pop.
REQ-026 reset=0 asynchronously mid-drain with fifo_count=4 -> all outputs zero immediately, no stale event after release.
REQ-027 Preload cycle_count to 32'hFFFFFFFE via forced run, 3 RUN cycles -> cycle_count=32'hFFFFFFFF.

Source files
------------

// File: rtl/wb_trace_unit_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_trace_unit_pkg : shared types and defaults for the writeback trace unit
// Revision 1.0
// ---------------------------------------------------------------------------
package wb_trace_unit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [4:0]  regnum;
    logic [31:0] data;
  } ev_t;

  localparam int          DEFAULT_DEPTH   = 8;
  localparam logic [31:0] DEFAULT_HALT_PC = 32'h58;

endpackage
`default_nettype wire

// File: rtl/wb_event_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_event_fifo : circular event buffer with push/pop, full/empty and count
// Revision 1.0
// ---------------------------------------------------------------------------
module wb_event_fifo
  import wb_trace_unit_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  ev_t                      i_data,
  input  logic                     i_pop,
  output ev_t                      o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  ev_t           r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  // A push into a full buffer is still accepted when the head leaves that edge.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_trace_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_trace_unit : captures writeback register updates into an event FIFO
// until the halt PC is fetched, then drains and reports completion.
// Revision 1.0
// ---------------------------------------------------------------------------
module wb_trace_unit
  import wb_trace_unit_pkg::*;
#(
  parameter int          DEPTH   = DEFAULT_DEPTH,
  parameter logic [31:0] HALT_PC = DEFAULT_HALT_PC
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            pc,
  input  logic                   wb_regwrite,
  input  logic [4:0]             wb_writereg,
  input  logic [31:0]            wb_result,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [4:0]             ev_reg,
  output logic [31:0]            ev_data,
  output logic                   halted,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [31:0]            cycle_count,
  output logic [31:0]            write_count
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_overflow;
  logic [31:0] r_cycle_count;
  logic [31:0] r_write_count;

  logic        w_qual;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  ev_t         w_head;
  ev_t         w_push_data;

  assign w_qual      = (r_state == RUN) && wb_regwrite && (wb_writereg != 5'd0);
  assign w_pop       = ev_valid && ev_ready;
  assign w_push_data = '{regnum: wb_writereg, data: wb_result};

  wb_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_qual),
    .i_data  (w_push_data),
    .i_pop   (ev_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_count)
  );

  assign ev_valid    = !w_empty;
  assign ev_reg      = w_head.regnum;
  assign ev_data     = w_head.data;
  assign halted      = (r_state == DONE);
  assign overflow    = r_overflow;
  assign cycle_count = r_cycle_count;
  assign write_count = r_write_count;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      RUN:     if (pc == HALT_PC) w_state_next = DRAIN;
      DRAIN:   if (w_empty)       w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow    <= 1'b0;
      r_cycle_count <= '0;
      r_write_count <= '0;
    end else begin
      // A dropped event still counts as a seen writeback.
      if (w_qual && w_full && !w_pop) r_overflow <= 1'b1;
      if (r_state == RUN) begin
        if (r_cycle_count != 32'hFFFF_FFFF) r_cycle_count <= r_cycle_count + 1'b1;
        if (w_qual && (r_write_count != 32'hFFFF_FFFF)) r_write_count <= r_write_count + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_trace_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_trace_unit : directed and randomized checks against a queue model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_wb_trace_unit;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] HALT_PC = 32'h58;
  localparam logic [31:0] MAXU    = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = '0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_writereg = '0;
  logic [31:0] wb_result = '0;
  logic        ev_ready = 1'b0;
  logic        ev_valid;
  logic [4:0]  ev_reg;
  logic [31:0] ev_data;
  logic        halted;
  logic        overflow;
  logic [3:0]  fifo_count;
  logic [31:0] cycle_count;
  logic [31:0] write_count;

  wb_trace_unit #(
    .DEPTH   (DEPTH),
    .HALT_PC (HALT_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .wb_regwrite (wb_regwrite),
    .wb_writereg (wb_writereg),
    .wb_result   (wb_result),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_reg      (ev_reg),
    .ev_data     (ev_data),
    .halted      (halted),
    .overflow    (overflow),
    .fifo_count  (fifo_count),
    .cycle_count (cycle_count),
    .write_count (write_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending events, sticky overflow, counters, run phase.
  logic [36:0] q[$];
  bit          m_ovf;
  logic [31:0] m_cycles;
  logic [31:0] m_writes;
  int          phase;   // 0 running, 1 draining, 2 done

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [36:0] head;
    head = (q.size() != 0) ? q[0] : 37'd0;
    chk({tag, ".ev_valid"},    64'(ev_valid),    64'(q.size() != 0));
    chk({tag, ".ev_reg"},      64'(ev_reg),      64'(head[36:32]));
    chk({tag, ".ev_data"},     64'(ev_data),     64'(head[31:0]));
    chk({tag, ".fifo_count"},  64'(fifo_count),  64'(q.size()));
    chk({tag, ".overflow"},    64'(overflow),    64'(m_ovf));
    chk({tag, ".halted"},      64'(halted),      64'(phase == 2));
    chk({tag, ".cycle_count"}, 64'(cycle_count), 64'(m_cycles));
    chk({tag, ".write_count"}, 64'(write_count), 64'(m_writes));
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf    = 1'b0;
    m_cycles = '0;
    m_writes = '0;
    phase    = 0;
  endtask

  // Entered and left at a falling edge; one rising edge in between.
  task automatic step(input string tag, input logic [31:0] p, input logic we,
                      input logic [4:0] wr, input logic [31:0] wd, input logic rdy);
    int sz;
    bit do_pop;
    bit qual;
    pc = p; wb_regwrite = we; wb_writereg = wr; wb_result = wd; ev_ready = rdy;
    sz     = q.size();
    do_pop = (sz != 0) && rdy;
    qual   = (phase == 0) && we && (wr != 5'd0);
    if (do_pop) void'(q.pop_front());
    if (qual) begin
      if (sz == DEPTH && !do_pop) m_ovf = 1'b1;
      else q.push_back({wr, wd});
    end
    if (phase == 0) begin
      if (m_cycles != MAXU) m_cycles++;
      if (qual && m_writes != MAXU) m_writes++;
      if (p == HALT_PC) phase = 1;
    end else if (phase == 1 && sz == 0) begin
      phase = 2;
    end
    @(posedge clk);
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(tag, 32'h0, 1'b0, 5'd0, 32'h0, rdy);
  endtask

  // Asynchronous assertion mid-cycle, release on a falling edge.
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rp;
    model_clear();
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b1;

    // Two real writes and one to r0, consumer always ready.
    step("seq22a", 32'h10, 1'b1, 5'd8, 32'd5, 1'b1);
    step("seq22b", 32'h14, 1'b1, 5'd9, 32'd7, 1'b1);
    step("seq22c", 32'h18, 1'b1, 5'd0, 32'd3, 1'b1);
    idle("seq22_idle", 3, 1'b1);
    chk("seq22.write_count", 64'(write_count), 64'd2);

    // Nine writes into an eight-deep buffer with no consumer.
    do_reset("rst23");
    for (int i = 0; i < 9; i++)
      step("ovf23", 32'h100 + 32'(4*i), 1'b1, 5'(i + 1), $urandom, 1'b0);
    chk("ovf23.count", 64'(fifo_count), 64'd8);
    chk("ovf23.overflow", 64'(overflow), 64'd1);
    chk("ovf23.writes", 64'(write_count), 64'd9);
    idle("ovf23_drain", 9, 1'b1);

    // Full buffer with simultaneous push and pop.
    do_reset("rst24");
    for (int i = 0; i < 8; i++)
      step("full24", 32'h200, 1'b1, 5'(i + 3), $urandom, 1'b0);
    step("full24_pp", 32'h204, 1'b1, 5'd31, 32'hCAFE_F00D, 1'b1);
    chk("full24.count", 64'(fifo_count), 64'd8);
    chk("full24.overflow", 64'(overflow), 64'd0);
    idle("full24_drain", 10, 1'b1);

    // Randomized running traffic, halt PC avoided.
    do_reset("rst_rand");
    for (int i = 0; i < 300; i++) begin
      rp = $urandom;
      if (rp == HALT_PC) rp = 32'h0;
      step("rand", rp, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
           $urandom, 1'($urandom_range(0, 2) == 0));
    end

    // Halt with a same-cycle write, consumer stalled, then drain to done.
    step("halt25", HALT_PC, 1'b1, 5'd2, 32'hAB, 1'b0);
    idle("halt25_stall", 3, 1'b0);
    for (int i = 0; i < 12; i++)
      step("drain25", 32'h0, 1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
    chk("halt25.halted", 64'(halted), 64'd1);

    // Reset while draining four events.
    do_reset("rst26a");
    for (int i = 0; i < 4; i++)
      step("fill26", 32'h300, 1'b1, 5'(i + 10), $urandom, 1'b0);
    step("halt26", HALT_PC, 1'b0, 5'd0, 32'h0, 1'b0);
    idle("drain26", 2, 1'b0);
    chk("drain26.count", 64'(fifo_count), 64'd4);
    do_reset("rst26b");
    idle("post26", 4, 1'b1);

    // Cycle counter saturation from a preloaded value.
    force dut.r_cycle_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_cycle_count;
    m_cycles = 32'hFFFF_FFFE;
    idle("sat27", 3, 1'b1);
    chk("sat27.cycle_count", 64'(cycle_count), 64'(MAXU));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
